// File: rtl/weight_server.sv
// Dual-port weight store with one-cycle reads, host load and a saturating nibble update FSM.
// The update FSM is built only when WSRV_UPDATE_EN is defined; otherwise upd_busy/upd_done tie to 0.
module weight_server #(
    parameter int              ADDR_W   = 4,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   INIT_W12 = 8'h12,
    parameter logic [DW-1:0]   INIT_W34 = 8'h21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              w_valid,
    output logic [DW-1:0]     w_data,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              wb_valid,
    output logic [DW-1:0]     wb_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DW-1:0]     ld_data,
    input  logic              upd_req,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic signed [3:0] upd_delta_hi,
    input  logic signed [3:0] upd_delta_lo,
    output logic              upd_busy,
    output logic              upd_done
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DW-1:0]     mem_q [DEPTH];
    logic              w_valid_q, wb_valid_q;
    logic [DW-1:0]     w_data_q, wb_data_q;
    logic              upd_we;
    logic [ADDR_W-1:0] upd_waddr;
    logic [DW-1:0]     upd_wdata;

`ifdef WSRV_UPDATE_EN
    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_READ  = 2'd1;
    localparam logic [1:0] U_WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] uaddr_q;
    logic [3:0]        dhi_q, dlo_q;
    logic [DW-1:0]     uval_q;
    logic              done_q;

    function automatic logic [3:0] sat4(input logic [3:0] a, input logic [3:0] d);
        logic signed [4:0] s;
        s = $signed({a[3], a}) + $signed({d[3], d});
        if (s > 5'sd7)       return 4'h7;
        else if (s < -5'sd8) return 4'h8;
        else                 return s[3:0];
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            U_IDLE:  if (upd_req) state_d = U_READ;
            U_READ:  state_d = U_WRITE;
            default: state_d = U_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= U_IDLE;
            uaddr_q <= '0;
            dhi_q   <= '0;
            dlo_q   <= '0;
            uval_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == U_WRITE);
            if (state_q == U_IDLE && upd_req) begin
                uaddr_q <= upd_addr;
                dhi_q   <= upd_delta_hi;
                dlo_q   <= upd_delta_lo;
            end
            // Latched once; a later host load to this address does not refresh it.
            if (state_q == U_READ) uval_q <= mem_q[uaddr_q];
        end
    end

    assign upd_we    = (state_q == U_WRITE);
    assign upd_waddr = uaddr_q;
    assign upd_wdata = {sat4(uval_q[7:4], dhi_q), sat4(uval_q[3:0], dlo_q)};
    assign upd_busy  = (state_q != U_IDLE);
    assign upd_done  = done_q;
`else
    logic unused_upd;
    assign unused_upd = ^{upd_req, upd_addr, upd_delta_hi, upd_delta_lo};
    assign upd_we    = 1'b0;
    assign upd_waddr = '0;
    assign upd_wdata = '0;
    assign upd_busy  = 1'b0;
    assign upd_done  = 1'b0;
`endif

    // Host load wins over the update write on the same address.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (!rst_n)
                mem_q[gi] <= (gi == 0) ? INIT_W12 : (gi == 1) ? INIT_W34 : '0;
            else if (ld_en && ld_addr == ADDR_W'(gi))
                mem_q[gi] <= ld_data;
            else if (upd_we && upd_waddr == ADDR_W'(gi))
                mem_q[gi] <= upd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_valid_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            w_data_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            w_valid_q  <= w_req;
            wb_valid_q <= wb_req;
            w_data_q   <= w_req  ? mem_q[w_addr]  : '0;
            wb_data_q  <= wb_req ? mem_q[wb_addr] : '0;
        end
    end

    assign w_valid  = w_valid_q;
    assign w_data   = w_data_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
endmodule

// File: tb/tb_weight_server.sv
// Self-checking bench: directed cases plus randomized traffic against an edge-level reference model.
// Follows WSRV_UPDATE_EN the same way as the design.
module tb_weight_server;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_req, wb_req, ld_en, upd_req;
    logic [3:0]        w_addr, wb_addr, ld_addr, upd_addr;
    logic [7:0]        ld_data;
    logic signed [3:0] upd_delta_hi, upd_delta_lo;
    logic              w_valid, wb_valid, upd_busy, upd_done;
    logic [7:0]        w_data, wb_data;

    weight_server dut (
        .clk(clk), .rst_n(rst_n),
        .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_valid(wb_valid), .wb_data(wb_data),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .upd_req(upd_req), .upd_addr(upd_addr),
        .upd_delta_hi(upd_delta_hi), .upd_delta_lo(upd_delta_lo),
        .upd_busy(upd_busy), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

`ifdef WSRV_UPDATE_EN
    localparam bit UPD_EN = 1'b1;
`else
    localparam bit UPD_EN = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference state: memory contents, pending update job and expected outputs.
    logic [7:0] mm [16];
    int         upd_left;   // edges until the update result lands (0 = no job)
    logic [3:0] j_addr, j_dhi, j_dlo;
    logic [7:0] j_val;
    logic       e_wv, e_wbv, e_done;
    logic [7:0] e_wd, e_wbd;

    function automatic logic [3:0] nib_add(logic [3:0] n, logic [3:0] d);
        int a, b, s;
        a = int'($signed(n));
        b = int'($signed(d));
        s = a + b;
        if (s > 7)  s = 7;
        if (s < -8) s = -8;
        return 4'(s);
    endfunction

    task automatic model_edge();
        logic [7:0] nm [16];
        if (!rst_n) begin
            foreach (mm[i]) mm[i] = 8'h00;
            mm[0] = 8'h12;
            mm[1] = 8'h21;
            upd_left = 0;
            {e_wv, e_wbv, e_done} = '0;
            e_wd = 8'h00;
            e_wbd = 8'h00;
            return;
        end
        e_wv  = w_req;
        e_wbv = wb_req;
        e_wd  = w_req  ? mm[w_addr]  : 8'h00;
        e_wbd = wb_req ? mm[wb_addr] : 8'h00;
        e_done = (upd_left == 1);
        nm = mm;
        if (upd_left == 1 && !(ld_en && ld_addr == j_addr))
            nm[j_addr] = {nib_add(j_val[7:4], j_dhi), nib_add(j_val[3:0], j_dlo)};
        if (ld_en) nm[ld_addr] = ld_data;
        if (upd_left == 2) begin
            j_val = mm[j_addr];
            upd_left = 1;
        end else if (upd_left == 1) begin
            upd_left = 0;
        end else if (upd_req && UPD_EN) begin
            j_addr = upd_addr;
            j_dhi = upd_delta_hi;
            j_dlo = upd_delta_lo;
            upd_left = 2;
        end
        mm = nm;
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1;
        {w_req, wb_req, ld_en, upd_req} = '0;
        {w_addr, wb_addr, ld_addr, upd_addr} = '0;
        ld_data = 8'h00;
        upd_delta_hi = 4'sd0;
        upd_delta_lo = 4'sd0;
    endtask

    // Inputs are set at negedge; apply one edge, update model, compare outputs.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("w_valid",  {7'd0, w_valid},  {7'd0, e_wv});
        chk("w_data",   w_data,           e_wd);
        chk("wb_valid", {7'd0, wb_valid}, {7'd0, e_wbv});
        chk("wb_data",  wb_data,          e_wbd);
        chk("upd_busy", {7'd0, upd_busy}, {7'd0, (upd_left != 0)});
        chk("upd_done", {7'd0, upd_done}, {7'd0, e_done});
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic read_lit(logic [3:0] a, logic [7:0] exp, string name);
        w_req = 1'b1; w_addr = a;
        @(posedge clk);
        model_edge();
        #1;
        chk(name, w_data, exp);
        chk("w_valid", {7'd0, w_valid}, 8'h01);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
    endtask

    task automatic start_upd(logic [3:0] a, logic [3:0] dh, logic [3:0] dl);
        upd_req = 1'b1; upd_addr = a; upd_delta_hi = dh; upd_delta_lo = dl;
    endtask

    initial begin
        idle_inputs();
        upd_left = 0;
        @(negedge clk);
        do_reset();
        chk("rst_w_data", w_data, 8'h00);

        // Reset contents and dual-channel same-cycle reads.
        read_lit(4'd0, 8'h12, "init_addr0");
        read_lit(4'd1, 8'h21, "init_addr1");
        w_req = 1'b1; w_addr = 4'd0; wb_req = 1'b1; wb_addr = 4'd1;
        cycle();
        chk("dual_w",  w_data,  8'h12);
        chk("dual_wb", wb_data, 8'h21);

        // Load, with a same-edge read returning the old value.
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 8'h7A; w_req = 1'b1; w_addr = 4'd3;
        cycle();
        chk("ld_old_value", w_data, 8'h00);
        read_lit(4'd3, 8'h7A, "ld_new_value");

        if (UPD_EN) begin
            // 7A + {+1,+3} -> 7D, busy two cycles, one done pulse.
            start_upd(4'd3, 4'sd1, 4'sd3);
            cycle();
            chk("busy_read", {7'd0, upd_busy}, 8'h01);
            cycle();
            chk("busy_write", {7'd0, upd_busy}, 8'h01);
            w_req = 1'b1; w_addr = 4'd3;
            cycle();
            chk("done_pulse", {7'd0, upd_done}, 8'h01);
            chk("read_during_write", w_data, 8'h7A);
            cycle();
            chk("done_once", {7'd0, upd_done}, 8'h00);
            read_lit(4'd3, 8'h7D, "upd_7D");

            // 88 + {-1,+2} -> 8A; second request while busy ignored.
            ld_en = 1'b1; ld_addr = 4'd2; ld_data = 8'h88;
            cycle();
            start_upd(4'd2, -4'sd1, 4'sd2);
            cycle();
            start_upd(4'd2, 4'sd7, 4'sd7);
            cycle();
            repeat (3) cycle();
            read_lit(4'd2, 8'h8A, "upd_8A");

            // Host load on the U_WRITE edge wins.
            start_upd(4'd4, 4'sd2, 4'sd2);
            cycle();
            cycle();
            ld_en = 1'b1; ld_addr = 4'd4; ld_data = 8'h55;
            cycle();
            chk("ld_prio_done", {7'd0, upd_done}, 8'h01);
            read_lit(4'd4, 8'h55, "ld_prio_55");

            // Reset during U_READ aborts the update.
            start_upd(4'd5, 4'sd3, 4'sd3);
            cycle();
            rst_n = 1'b0;
            cycle();
            chk("abort_busy", {7'd0, upd_busy}, 8'h00);
            cycle();
            chk("abort_no_done", {7'd0, upd_done}, 8'h00);
            read_lit(4'd5, 8'h00, "abort_no_write");
            read_lit(4'd3, 8'h00, "abort_mem_init");
        end else begin
            start_upd(4'd3, 4'sd1, 4'sd3);
            cycle();
            chk("noupd_busy", {7'd0, upd_busy}, 8'h00);
            repeat (3) cycle();
            chk("noupd_done", {7'd0, upd_done}, 8'h00);
            read_lit(4'd3, 8'h7A, "noupd_unchanged");
        end

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            rst_n   = ($urandom_range(0, 79) != 0);
            w_req   = 1'($urandom);
            wb_req  = 1'($urandom);
            w_addr  = 4'($urandom);
            wb_addr = 4'($urandom);
            ld_en   = ($urandom_range(0, 3) == 0);
            ld_addr = 4'($urandom_range(0, 7));
            ld_data = 8'($urandom);
            upd_req = ($urandom_range(0, 2) == 0);
            upd_addr = 4'($urandom_range(0, 7));
            upd_delta_hi = 4'($urandom);
            upd_delta_lo = 4'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
